cpu_status_uart: RTL

Serial status reporter placed directly downstream of the RISC-V core on the Tang Nano 9K board top. It consumes the core's `debug_pc`, `success` and `exit` signals and drives `uart_tx`. When the core signals exit, the block sends a fixed 15-byte ASCII line: PASS or FAIL followed by the PC in hex. It runs on the ungated board clock, so it keeps transmitting after the core clock is halted.

---
 rtl/cpu_status_uart.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cpu_status_uart.sv
// Serial status reporter: on a rising core exit it sends "PASS xxxxxxxx\r\n" or "FAIL xxxxxxxx\r\n" (8N1).
// Optional heartbeat "RUN  xxxxxxxx\r\n" lines when CPU_STATUS_UART_PERIODIC_EN is defined.
module cpu_status_uart #(
  parameter int CLOCK_HZ      = 27_000_000,
  parameter int BAUD          = 115200,
  parameter int PERIOD_CYCLES = 27_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] debug_pc,
  input  logic        success,
  input  logic        exit,
  output logic        uart_tx,
  output logic        busy,
  output logic [7:0]  report_count
);

  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BYTE = 4'd14;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("cpu_status_uart: CLOCK_HZ/BAUD must be at least 2");
    end
    if (PERIOD_CYCLES < 1) begin : g_bad_period
      $error("cpu_status_uart: PERIOD_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  typedef enum logic [1:0] {K_PASS, K_FAIL, K_RUN} kind_t;

  state_t state, state_next;
  kind_t kind_q;
  logic [CW-1:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [3:0] byte_idx;
  logic [31:0] pc_q;
  logic exit_d;
  logic tick, exit_trig, hb_fire, start_line, line_done;
  logic [7:0] cur_byte;
  logic tx_d, busy_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] line_byte(input logic [3:0] idx, input kind_t kind,
                                           input logic [31:0] pc);
    logic [31:0] tag;
    logic [7:0] b;
    case (kind)
      K_PASS:  tag = 32'h5041_5353;
      K_RUN:   tag = 32'h5255_4E20;
      default: tag = 32'h4641_494C;
    endcase
    b = 8'h0A;
    if (idx <= 4'd3)
      b = 8'(tag >> (8 * (3 - int'(idx))));
    else if (idx == 4'd4)
      b = 8'h20;
    else if (idx <= 4'd12)
      b = hex_ascii(4'(pc >> (4 * (12 - int'(idx)))));
    else if (idx == 4'd13)
      b = 8'h0D;
    return b;
  endfunction

  // busy lags state by one cycle, so a trigger is only taken once busy has actually dropped
  assign exit_trig  = exit & ~exit_d;
  assign start_line = (state == S_IDLE) && !busy && (exit_trig || hb_fire);
  assign tick       = (bit_cnt == LAST_TICK);
  assign line_done  = (state == S_IDLE) && busy;
  assign cur_byte   = line_byte(byte_idx, kind_q, pc_q);

`ifdef CPU_STATUS_UART_PERIODIC_EN
  localparam int TW = (PERIOD_CYCLES < 2) ? 1 : $clog2(PERIOD_CYCLES + 1);
  logic [TW-1:0] hb_timer;

  // heartbeat timer only advances while fully idle
  always_ff @(posedge clock) begin
    if (reset)
      hb_timer <= '0;
    else if (start_line || busy || (state != S_IDLE))
      hb_timer <= '0;
    else
      hb_timer <= hb_timer + 1'b1;
  end

  assign hb_fire = (hb_timer == TW'(PERIOD_CYCLES - 1));
`else
  assign hb_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_line) state_next = S_START;
      S_START: if (tick) state_next = S_DATA;
      S_DATA:  if (tick && (bit_idx == 3'd7)) state_next = S_STOP;
      S_STOP:  if (tick) state_next = (byte_idx == LAST_BYTE) ? S_IDLE : S_START;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state != S_IDLE);
    case (state)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_idx];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      uart_tx <= 1'b1;
      busy    <= 1'b0;
    end else begin
      uart_tx <= tx_d;
      busy    <= busy_d;
    end
  end

  // the exit trigger takes priority over the heartbeat when both fire together
  always_ff @(posedge clock) begin
    if (reset) begin
      exit_d       <= 1'b0;
      pc_q         <= '0;
      kind_q       <= K_PASS;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      report_count <= '0;
    end else begin
      exit_d <= exit;
      if (start_line) begin
        pc_q   <= debug_pc;
        kind_q <= exit_trig ? (success ? K_PASS : K_FAIL) : K_RUN;
      end
      if ((state == S_IDLE) || tick)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 1'b1;
      if (state == S_IDLE)
        bit_idx <= '0;
      else if ((state == S_DATA) && tick)
        bit_idx <= bit_idx + 1'b1;
      if (state == S_IDLE)
        byte_idx <= '0;
      else if ((state == S_STOP) && tick)
        byte_idx <= (byte_idx == LAST_BYTE) ? 4'd0 : byte_idx + 1'b1;
      if (line_done)
        report_count <= report_count + 1'b1;
    end
  end

endmodule
